// File: rtl/uart_tx_buf_pkg.sv
// uart_tx_buf_pkg: shared project constants and FSM encoding for the UART transmit buffer
package uart_tx_buf_pkg;
   localparam int CLOCK_FRQ = 50_000_000;
   localparam int BAUD_MAX = 115_200;
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LOAD = 2'd1;
   localparam logic [1:0] ST_WAIT = 2'd2;
   typedef enum logic [1:0] {IDLE = ST_IDLE, LOAD = ST_LOAD, WAIT = ST_WAIT} state_t;
endpackage

// File: rtl/uart_tx_buf_if.sv
// uart_tx_buf_if: producer handshake, serializer issue and status signals of the transmit buffer
interface uart_tx_buf_if #(
   parameter int DW = 8,
   parameter int DEPTH = 16
);
   localparam int AW = $clog2(DEPTH);
   logic [DW-1:0] in_data;
   logic in_vld;
   logic in_rdy;
   logic [DW-1:0] tx_din;
   logic tx_din_vld;
   logic tx_busy;
   logic [AW:0] fifo_level;
   logic ovf_err;
   modport master (output in_data, in_vld, tx_busy, input in_rdy, tx_din, tx_din_vld, fifo_level, ovf_err);
   modport slave (input in_data, in_vld, tx_busy, output in_rdy, tx_din, tx_din_vld, fifo_level, ovf_err);
endinterface

// File: rtl/uart_tx_buf_sync_fifo.sv
// uart_tx_buf_sync_fifo: synchronous FIFO with registered read data and an AW+1 bit fill level
module uart_tx_buf_sync_fifo #(
   parameter int DW = 8,
   parameter int DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       wr_en,
   input  logic [DW-1:0]              wr_data,
   input  logic                       rd_en,
   output logic [DW-1:0]              rd_data,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     level
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wp, rp;
   logic [AW:0] cnt;
   logic wr_ok, rd_ok;
   assign full = cnt == LW'(DEPTH);
   assign empty = cnt == '0;
   assign level = cnt;
   // a read never frees a slot for a same-cycle write when full
   assign wr_ok = wr_en && !full;
   assign rd_ok = rd_en && !empty;
   always_ff @(posedge clk) if (wr_ok) mem[wp] <= wr_data;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wp <= '0;
         rp <= '0;
         cnt <= '0;
         rd_data <= '0;
      end else begin
         if (wr_ok) wp <= wp + AW'(1);
         if (rd_ok) rp <= rp + AW'(1);
         if (rd_ok) rd_data <= mem[rp];
         cnt <= cnt + LW'(wr_ok) - LW'(rd_ok);
      end
endmodule

// File: rtl/uart_tx_buf.sv
// uart_tx_buf: buffers producer bytes and issues them one at a time to the UART serializer
module uart_tx_buf
   import uart_tx_buf_pkg::*;
#(
   parameter int DW = 8,
   parameter int DEPTH = 16
) (
   input logic clk,
   input logic rst_n,
   uart_tx_buf_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   state_t state, nxt;
   logic rd_en, full, empty, tx_vld_q, ovf_q;
   logic [DW-1:0] rd_data, tx_din_q;
   logic [AW:0] level;
   uart_tx_buf_sync_fifo #(.DW(DW), .DEPTH(DEPTH)) u_sync_fifo (
      .clk(clk),
      .rst_n(rst_n),
      .wr_en(bus.in_vld),
      .wr_data(bus.in_data),
      .rd_en(rd_en),
      .rd_data(rd_data),
      .full(full),
      .empty(empty),
      .level(level)
   );
   assign bus.in_rdy = !full;
   assign bus.fifo_level = level;
   assign bus.tx_din = tx_din_q;
   assign bus.tx_din_vld = tx_vld_q;
   assign bus.ovf_err = ovf_q;
   // tx_busy covers the pulse cycle too, so WAIT holds until the frame is really over
   always_comb begin
      rd_en = state == IDLE && !empty && !bus.tx_busy;
      nxt = rd_en ? LOAD : state == LOAD ? WAIT : (state == WAIT && !bus.tx_busy) ? IDLE : state;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= IDLE;
         tx_vld_q <= 1'b0;
         tx_din_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         state <= nxt;
         tx_vld_q <= state == LOAD;
         if (state == LOAD) tx_din_q <= rd_data;
         if (bus.in_vld && full) ovf_q <= 1'b1;
      end
endmodule

// File: tb/tb_uart_tx_buf.sv
// tb_uart_tx_buf: drives uart_tx_buf against a serializer stand-in and decodes its line output
module tb_uart_tx_buf;
   import uart_tx_buf_pkg::*;
   localparam int DW = 8;
   localparam int DEPTH = 16;
   // 434 clocks per bit at 50 MHz / 115200, scaled down so the run stays short
   localparam int BIT_CYC = CLOCK_FRQ / BAUD_MAX / 27;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic force_busy = 1'b0;
   logic ser_busy, line, dec_on, acc;
   logic [9:0] sh;
   logic [7:0] dbyte;
   int bit_i, cyc, dcnt;
   int checks = 0, failures = 0, pulses = 0, viol = 0, dbl = 0, frame_err = 0;
   logic prev_vld = 1'b0;
   logic [7:0] exp_q[$], rx_q[$];

   always #10 clk = ~clk;

   uart_tx_buf_if #(.DW(DW), .DEPTH(DEPTH)) bus ();
   uart_tx_buf #(.DW(DW), .DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   assign bus.tx_busy = bus.tx_din_vld | ser_busy | force_busy;

   // serializer stand-in: 8N1 frame, LSB first, latched on the start pulse
   always @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         ser_busy <= 1'b0;
         line <= 1'b1;
         bit_i <= 0;
         cyc <= 0;
      end else if (!ser_busy) begin
         if (bus.tx_din_vld) begin
            ser_busy <= 1'b1;
            sh <= {1'b1, bus.tx_din, 1'b0};
            line <= 1'b0;
            bit_i <= 0;
            cyc <= 0;
         end
      end else if (cyc == BIT_CYC - 1) begin
         cyc <= 0;
         if (bit_i == 9) begin
            ser_busy <= 1'b0;
            line <= 1'b1;
         end else begin
            bit_i <= bit_i + 1;
            line <= sh[bit_i + 1];
         end
      end else cyc <= cyc + 1;

   // line decoder: mid-bit sampling from the falling start edge
   always @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         dec_on <= 1'b0;
         dcnt <= 0;
      end else if (!dec_on) begin
         if (!line) begin
            dec_on <= 1'b1;
            dcnt <= 0;
         end
      end else begin
         dcnt <= dcnt + 1;
         for (int i = 0; i < 8; i++)
            if (dcnt == BIT_CYC / 2 + BIT_CYC * (i + 1)) dbyte[i] <= line;
         if (dcnt == BIT_CYC / 2 + BIT_CYC * 9) begin
            dec_on <= 1'b0;
            if (!line) frame_err++;
            rx_q.push_back(dbyte);
         end
      end

   always @(negedge clk) begin
      if (bus.tx_din_vld) begin
         pulses++;
         if (ser_busy || force_busy) viol++;
         if (prev_vld) dbl++;
      end
      prev_vld = bus.tx_din_vld;
   end

   task automatic send(input logic [7:0] d);
      bus.in_vld = 1'b1;
      bus.in_data = d;
      @(negedge clk);
      acc = bus.in_rdy;
      if (acc) exp_q.push_back(d);
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(output logic ok);
      int quiet = 0;
      ok = 1'b0;
      for (int n = 0; n < 20000; n++) begin
         @(negedge clk);
         quiet = (bus.fifo_level == 0 && !bus.tx_busy && !dec_on) ? quiet + 1 : 0;
         if (quiet >= 8) begin
            ok = 1'b1;
            break;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks += 5;
      if (bus.tx_din !== 8'h00) begin failures++; $display("FAIL reset_tx_din: got %h want 00", bus.tx_din); end
      if (bus.tx_din_vld !== 1'b0) begin failures++; $display("FAIL reset_vld: got %b want 0", bus.tx_din_vld); end
      if (bus.fifo_level !== 5'd0) begin failures++; $display("FAIL reset_level: got %0d want 0", bus.fifo_level); end
      if (bus.ovf_err !== 1'b0) begin failures++; $display("FAIL reset_ovf: got %b want 0", bus.ovf_err); end
      if (bus.in_rdy !== 1'b1) begin failures++; $display("FAIL reset_rdy: got %b want 1", bus.in_rdy); end
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_single;
      logic ok;
      int c0 = pulses;
      exp_q.delete();
      rx_q.delete();
      send(8'hA5);
      bus.in_vld = 1'b0;
      @(negedge clk);
      checks += 2;
      if (bus.fifo_level !== 5'd1) begin failures++; $display("FAIL single_level_k: got %0d want 1", bus.fifo_level); end
      if (bus.tx_din_vld !== 1'b0) begin failures++; $display("FAIL single_vld_k: got %b want 0", bus.tx_din_vld); end
      @(negedge clk);
      checks += 2;
      if (bus.fifo_level !== 5'd0) begin failures++; $display("FAIL single_level_k1: got %0d want 0", bus.fifo_level); end
      if (bus.tx_din_vld !== 1'b0) begin failures++; $display("FAIL single_vld_k1: got %b want 0", bus.tx_din_vld); end
      @(negedge clk);
      checks += 2;
      if (bus.tx_din_vld !== 1'b1) begin failures++; $display("FAIL single_vld_k2: got %b want 1", bus.tx_din_vld); end
      if (bus.tx_din !== 8'hA5) begin failures++; $display("FAIL single_din: got %h want a5", bus.tx_din); end
      @(negedge clk);
      checks += 2;
      if (bus.tx_din_vld !== 1'b0) begin failures++; $display("FAIL single_vld_k3: got %b want 0", bus.tx_din_vld); end
      if (bus.tx_din !== 8'hA5) begin failures++; $display("FAIL single_din_hold: got %h want a5", bus.tx_din); end
      wait_idle(ok);
      checks += 3;
      if (!ok) begin failures++; $display("FAIL single_drain: got timeout want idle"); end
      if (rx_q.size() !== 1 || rx_q[0] !== 8'hA5) begin failures++; $display("FAIL single_line: got %p want a5", rx_q); end
      if (pulses - c0 !== 1) begin failures++; $display("FAIL single_pulses: got %0d want 1", pulses - c0); end
   endtask

   task automatic test_burst;
      logic ok;
      int c0 = pulses;
      int v0 = viol;
      exp_q.delete();
      rx_q.delete();
      send(8'h55);
      send(8'hAA);
      send(8'h0F);
      bus.in_vld = 1'b0;
      wait_idle(ok);
      checks += 5;
      if (!ok) begin failures++; $display("FAIL burst_drain: got timeout want idle"); end
      if (rx_q.size() !== 3) begin failures++; $display("FAIL burst_count: got %0d want 3", rx_q.size()); end
      else if (rx_q[0] !== 8'h55 || rx_q[1] !== 8'hAA || rx_q[2] !== 8'h0F) begin
         failures++; $display("FAIL burst_order: got %p want 55 aa 0f", rx_q);
      end
      if (pulses - c0 !== 3) begin failures++; $display("FAIL burst_pulses: got %0d want 3", pulses - c0); end
      if (viol !== v0) begin failures++; $display("FAIL burst_busy_pulse: got %0d want %0d", viol, v0); end
      if (dbl !== 0) begin failures++; $display("FAIL burst_pulse_width: got %0d long pulses want 0", dbl); end
   endtask

   task automatic test_overflow;
      logic ok;
      logic dropped = 1'b0;
      int acc_n = 0;
      logic [4:0] lvl_drop = '0;
      rx_q.delete();
      for (int i = 0; i < 20; i++) begin
         bus.in_vld = 1'b1;
         bus.in_data = 8'(i);
         @(negedge clk);
         if (bus.in_rdy) acc_n++;
         else if (!dropped) begin
            dropped = 1'b1;
            lvl_drop = bus.fifo_level;
         end
         @(posedge clk);
         #1;
      end
      bus.in_vld = 1'b0;
      @(negedge clk);
      checks += 4;
      if (acc_n !== 17) begin failures++; $display("FAIL ovf_accepted: got %0d want 17", acc_n); end
      if (!dropped || lvl_drop !== 5'd16) begin failures++; $display("FAIL ovf_drop_level: got %0d want 16", lvl_drop); end
      if (bus.ovf_err !== 1'b1) begin failures++; $display("FAIL ovf_sticky: got %b want 1", bus.ovf_err); end
      if (bus.fifo_level !== 5'd16) begin failures++; $display("FAIL ovf_level: got %0d want 16", bus.fifo_level); end
      wait_idle(ok);
      checks += 3;
      if (!ok) begin failures++; $display("FAIL ovf_drain: got timeout want idle"); end
      if (bus.ovf_err !== 1'b1) begin failures++; $display("FAIL ovf_still_set: got %b want 1", bus.ovf_err); end
      if (rx_q.size() !== 17) begin failures++; $display("FAIL ovf_line_count: got %0d want 17", rx_q.size()); end
      else for (int i = 0; i < 17; i++) begin
         checks++;
         if (rx_q[i] !== 8'(i)) begin failures++; $display("FAIL ovf_line_%0d: got %h want %h", i, rx_q[i], 8'(i)); end
      end
   endtask

   task automatic test_force_busy;
      logic ok;
      int c0, got = 0;
      exp_q.delete();
      rx_q.delete();
      force_busy = 1'b1;
      c0 = pulses;
      send(8'($urandom));
      send(8'($urandom));
      bus.in_vld = 1'b0;
      repeat (40) @(negedge clk);
      checks += 2;
      if (pulses !== c0) begin failures++; $display("FAIL force_no_pulse: got %0d pulses want 0", pulses - c0); end
      if (bus.fifo_level !== 5'd2) begin failures++; $display("FAIL force_level: got %0d want 2", bus.fifo_level); end
      force_busy = 1'b0;
      for (int n = 1; n <= 4; n++) begin
         @(negedge clk);
         if (bus.tx_din_vld && got == 0) got = n;
      end
      wait_idle(ok);
      checks += 3;
      if (got < 1 || got > 2) begin failures++; $display("FAIL force_release_latency: got %0d cycles want 1..2", got); end
      if (!ok) begin failures++; $display("FAIL force_drain: got timeout want idle"); end
      if (rx_q !== exp_q) begin failures++; $display("FAIL force_line: got %p want %p", rx_q, exp_q); end
   endtask

   task automatic test_simultaneous;
      logic ok;
      exp_q.delete();
      rx_q.delete();
      force_busy = 1'b1;
      send(8'($urandom));
      bus.in_vld = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.fifo_level !== 5'd1) begin failures++; $display("FAIL simul_pre_level: got %0d want 1", bus.fifo_level); end
      force_busy = 1'b0;
      bus.in_vld = 1'b1;
      bus.in_data = 8'($urandom);
      exp_q.push_back(bus.in_data);
      @(posedge clk);
      #1;
      bus.in_vld = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.fifo_level !== 5'd1) begin failures++; $display("FAIL simul_level: got %0d want 1", bus.fifo_level); end
      wait_idle(ok);
      checks += 2;
      if (!ok) begin failures++; $display("FAIL simul_drain: got timeout want idle"); end
      if (rx_q !== exp_q) begin failures++; $display("FAIL simul_order: got %p want %p", rx_q, exp_q); end
   endtask

   task automatic test_reset_mid;
      int c0 = pulses;
      exp_q.delete();
      rx_q.delete();
      for (int i = 0; i < 5; i++) send(8'($urandom));
      bus.in_vld = 1'b0;
      for (int n = 0; n < 20 && !ser_busy; n++) @(negedge clk);
      repeat (BIT_CYC * 4) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks += 5;
      if (bus.tx_din !== 8'h00) begin failures++; $display("FAIL rmid_tx_din: got %h want 00", bus.tx_din); end
      if (bus.tx_din_vld !== 1'b0) begin failures++; $display("FAIL rmid_vld: got %b want 0", bus.tx_din_vld); end
      if (bus.fifo_level !== 5'd0) begin failures++; $display("FAIL rmid_level: got %0d want 0", bus.fifo_level); end
      if (bus.ovf_err !== 1'b0) begin failures++; $display("FAIL rmid_ovf: got %b want 0", bus.ovf_err); end
      if (bus.in_rdy !== 1'b1) begin failures++; $display("FAIL rmid_rdy: got %b want 1", bus.in_rdy); end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (BIT_CYC * 40) @(negedge clk);
      checks += 2;
      if (pulses - c0 !== 1) begin failures++; $display("FAIL rmid_pulses: got %0d want 1", pulses - c0); end
      if (rx_q.size() !== 0) begin failures++; $display("FAIL rmid_frames: got %0d want 0", rx_q.size()); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_random;
      logic ok;
      exp_q.delete();
      rx_q.delete();
      for (int i = 0; i < 24; i++) begin
         int g = $urandom_range(0, 3);
         repeat (g) begin
            @(posedge clk);
            #1;
         end
         for (int w = 0; w < 5000 && !bus.in_rdy; w++) begin
            @(posedge clk);
            #1;
         end
         send(8'($urandom));
         bus.in_vld = 1'b0;
      end
      wait_idle(ok);
      checks += 5;
      if (!ok) begin failures++; $display("FAIL rand_drain: got timeout want idle"); end
      if (exp_q.size() !== 24) begin failures++; $display("FAIL rand_accepted: got %0d want 24", exp_q.size()); end
      if (rx_q !== exp_q) begin failures++; $display("FAIL rand_line: got %p want %p", rx_q, exp_q); end
      if (bus.ovf_err !== 1'b0) begin failures++; $display("FAIL rand_ovf: got %b want 0", bus.ovf_err); end
      if (frame_err !== 0) begin failures++; $display("FAIL rand_stop_bits: got %0d bad want 0", frame_err); end
   endtask

   initial begin
      bus.in_vld = 1'b0;
      bus.in_data = '0;
      test_reset();
      test_single();
      test_burst();
      test_overflow();
      test_force_busy();
      test_simultaneous();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog");
   end
endmodule
